// File: rtl/ipv4_pkg.sv
// Shared IPv4 header definitions: field constants, wire-order header struct,
// tx FSM state type and the end-around checksum fold.
package ipv4_pkg;

  localparam int IPV4_VERSION = 4;
  localparam int IPV4_IHL     = 5;
  localparam int IPV4_HEAD_N  = 20;
  localparam int CS_W         = 16;

  // Field order matches wire order: bits [159:152] are wire byte 0.
  typedef struct packed {
    logic [3:0]      version;
    logic [3:0]      ihl;
    logic [5:0]      dscp;
    logic [1:0]      ecn;
    logic [15:0]     tot_len;
    logic [15:0]     id;
    logic [2:0]      flags;
    logic [12:0]     frag_off;
    logic [7:0]      ttl;
    logic [7:0]      protocol;
    logic [CS_W-1:0] checksum;
    logic [31:0]     src_addr;
    logic [31:0]     dst_addr;
  } ipv4_head_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_FOLD = 2'd2,
    ST_SEND = 2'd3
  } tx_state_e;

  // Two folds suffice: nine 16-bit words never exceed 20 bits, and the first
  // fold of a 20-bit sum leaves at most a single carry.
  function automatic logic [CS_W-1:0] ipv4_cs_fold(input logic [19:0] sum);
    logic [16:0] f1;
    logic [16:0] f2;
    f1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    f2 = {1'b0, f1[15:0]} + {16'd0, f1[16]};
    return f2[15:0];
  endfunction

endpackage

// File: rtl/ipv4_cs_sum.sv
// Registered IPv4 header checksum: nine-word sum on the start cycle, folded and
// inverted one cycle later. Shared with the rx checksum checker.
module ipv4_cs_sum
  import ipv4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [8:0][15:0]     words_i,
  output logic [CS_W-1:0]      cs_o
);

  logic [19:0]     sum_d;
  logic [19:0]     sum_q;
  logic            fold_v_q;
  logic [CS_W-1:0] cs_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + {4'd0, words_i[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q    <= '0;
      fold_v_q <= 1'b0;
      cs_q     <= '0;
    end else begin
      fold_v_q <= start_i;
      if (start_i) begin
        sum_q <= sum_d;
      end
      if (fold_v_q) begin
        cs_q <= ~ipv4_cs_fold(sum_q);
      end
    end
  end

  assign cs_o = cs_q;

endmodule

// File: rtl/ipv4_head_tx_stream.sv
// IPv4 header generator for the UDP tx path: accepts one request per packet,
// checksums the header in two cycles and streams it as DATA_W-wide beats.
//
// state | meaning
// IDLE  | ready for a request; rejects total lengths above 16'hFFFF
// SUM   | nine header words summed into the checksum pipeline
// FOLD  | checksum folded and inverted, Identification advanced
// SEND  | header beats offered downstream until the last one is taken
module ipv4_head_tx_stream
  import ipv4_pkg::*;
#(
  parameter int         DATA_W   = 64,
  parameter int         LEN_W    = 16,
  parameter logic [5:0] DSCP     = 6'h2e,
  parameter logic [1:0] ECN      = 2'b00,
  parameter logic [7:0] TTL      = 8'd64,
  parameter logic [7:0] PROTOCOL = 8'd17,
  parameter logic       DF       = 1'b1,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_v_i,
  output logic                req_ready_o,
  input  logic [LEN_W-1:0]    data_len_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  output logic                len_err_o,
  output logic                head_v_o,
  input  logic                head_ready_i,
  output logic [DATA_W-1:0]   head_data_o,
  output logic [DATA_W/8-1:0] head_keep_o,
  output logic                head_last_o
);

  localparam int BPB    = DATA_W / 8;
  localparam int N_BEAT = (IPV4_HEAD_N + BPB - 1) / BPB;
  localparam int BEAT_W = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;
  localparam int IDX_W  = $clog2(N_BEAT * BPB);

  tx_state_e state_q;
  tx_state_e state_d;

  logic [15:0]       len_q;
  logic [31:0]       src_q;
  logic [31:0]       dst_q;
  logic [15:0]       id_q;
  logic [15:0]       pkt_id_q;
  logic [BEAT_W-1:0] beat_q;
  logic              len_err_q;

  logic              accept;
  logic [LEN_W:0]    tot_w;
  logic [31:0]       tot_ext;
  logic              len_bad;
  logic              last_beat;

  ipv4_head_t        hdr;
  logic [159:0]      hdr_bits;
  logic [8:0][15:0]  cs_words;
  logic [CS_W-1:0]   cs;
  logic [7:0]        hbytes [IPV4_HEAD_N];
  logic [IDX_W-1:0]  idx;

  assign accept    = req_v_i && req_ready_o;
  assign tot_w     = {1'b0, data_len_i} + (LEN_W+1)'(IPV4_HEAD_N);
  assign tot_ext   = 32'(tot_w);
  assign len_bad   = tot_w[LEN_W] || (tot_ext > 32'h0000_FFFF);
  assign last_beat = (beat_q == BEAT_W'(N_BEAT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !len_bad) state_d = ST_SUM;
      ST_SUM:  state_d = ST_FOLD;
      ST_FOLD: state_d = ST_SEND;
      ST_SEND: if (head_ready_i && last_beat) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      pkt_id_q  <= '0;
      id_q      <= ID_INIT;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= accept && len_bad;
      if (accept && !len_bad) begin
        len_q    <= tot_ext[15:0];
        src_q    <= src_addr_i;
        dst_q    <= dst_addr_i;
        pkt_id_q <= id_q;
      end
      if (state_q == ST_FOLD) begin
        id_q   <= id_q + 16'd1;
        beat_q <= '0;
      end else if (state_q == ST_SEND && head_ready_i) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    hdr          = '0;
    hdr.version  = 4'(IPV4_VERSION);
    hdr.ihl      = 4'(IPV4_IHL);
    hdr.dscp     = DSCP;
    hdr.ecn      = ECN;
    hdr.tot_len  = len_q;
    hdr.id       = pkt_id_q;
    hdr.flags    = {1'b0, DF, 1'b0};
    hdr.frag_off = '0;
    hdr.ttl      = TTL;
    hdr.protocol = PROTOCOL;
    hdr.checksum = cs;
    hdr.src_addr = src_q;
    hdr.dst_addr = dst_q;
  end

  assign hdr_bits = hdr;
  // The checksum word itself is left out of the sum, i.e. counted as zero.
  assign cs_words = {hdr_bits[159:80], hdr_bits[63:0]};

  ipv4_cs_sum u_cs_sum (
    .clk     (clk),
    .reset   (reset),
    .start_i (state_q == ST_SUM),
    .words_i (cs_words),
    .cs_o    (cs)
  );

  always_comb begin
    for (int j = 0; j < IPV4_HEAD_N; j++) begin
      hbytes[j] = hdr_bits[159 - 8*j -: 8];
    end
  end

  always_comb begin
    req_ready_o = (state_q == ST_IDLE) && !reset;
    head_v_o    = (state_q == ST_SEND);
    head_last_o = head_v_o && last_beat;
    len_err_o   = len_err_q;
    head_data_o = '0;
    head_keep_o = '0;
    idx         = '0;
    if (head_v_o) begin
      for (int k = 0; k < BPB; k++) begin
        idx = IDX_W'(int'(beat_q) * BPB + k);
        if (idx < IDX_W'(IPV4_HEAD_N)) begin
          head_data_o[8*k +: 8] = hbytes[idx];
          head_keep_o[k]        = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ipv4_head_tx_stream.sv
// Directed plus randomised checks of the IPv4 tx header streamer at four beat
// widths against a byte-level header model.
module tb_ipv4_head_tx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req_v;
  logic [3:0]  hready;
  logic [15:0] dlen  [4];
  logic [31:0] src_a [4];
  logic [31:0] dst_a [4];

  wire [3:0]   rdy, lerr, hv, hl;
  wire [63:0]  hd0;
  wire [7:0]   hk0;
  wire [15:0]  hd1;
  wire [1:0]   hk1;
  wire [31:0]  hd2;
  wire [3:0]   hk2;
  wire [127:0] hd3;
  wire [15:0]  hk3;

  logic [127:0] hd [4];
  logic [15:0]  hk [4];

  always_comb begin
    hd[0] = {64'd0, hd0};
    hd[1] = {112'd0, hd1};
    hd[2] = {96'd0, hd2};
    hd[3] = hd3;
    hk[0] = {8'd0, hk0};
    hk[1] = {14'd0, hk1};
    hk[2] = {12'd0, hk2};
    hk[3] = hk3;
  end

  ipv4_head_tx_stream #(.DATA_W(64), .DSCP(6'h00), .ID_INIT(16'h0000)) u0 (
    .clk(clk), .reset(reset), .req_v_i(req_v[0]), .req_ready_o(rdy[0]),
    .data_len_i(dlen[0]), .src_addr_i(src_a[0]), .dst_addr_i(dst_a[0]),
    .len_err_o(lerr[0]), .head_v_o(hv[0]), .head_ready_i(hready[0]),
    .head_data_o(hd0), .head_keep_o(hk0), .head_last_o(hl[0]));

  ipv4_head_tx_stream #(.DATA_W(16), .ID_INIT(16'hFFFF)) u1 (
    .clk(clk), .reset(reset), .req_v_i(req_v[1]), .req_ready_o(rdy[1]),
    .data_len_i(dlen[1]), .src_addr_i(src_a[1]), .dst_addr_i(dst_a[1]),
    .len_err_o(lerr[1]), .head_v_o(hv[1]), .head_ready_i(hready[1]),
    .head_data_o(hd1), .head_keep_o(hk1), .head_last_o(hl[1]));

  ipv4_head_tx_stream #(.DATA_W(32)) u2 (
    .clk(clk), .reset(reset), .req_v_i(req_v[2]), .req_ready_o(rdy[2]),
    .data_len_i(dlen[2]), .src_addr_i(src_a[2]), .dst_addr_i(dst_a[2]),
    .len_err_o(lerr[2]), .head_v_o(hv[2]), .head_ready_i(hready[2]),
    .head_data_o(hd2), .head_keep_o(hk2), .head_last_o(hl[2]));

  ipv4_head_tx_stream #(.DATA_W(128)) u3 (
    .clk(clk), .reset(reset), .req_v_i(req_v[3]), .req_ready_o(rdy[3]),
    .data_len_i(dlen[3]), .src_addr_i(src_a[3]), .dst_addr_i(dst_a[3]),
    .len_err_o(lerr[3]), .head_v_o(hv[3]), .head_ready_i(hready[3]),
    .head_data_o(hd3), .head_keep_o(hk3), .head_last_o(hl[3]));

  int n_chk = 0;
  int n_err = 0;

  int          bpb_of [4]     = '{8, 2, 4, 16};
  int          nb_of  [4]     = '{3, 10, 5, 2};
  logic [5:0]  dscp_of [4]    = '{6'h00, 6'h2e, 6'h2e, 6'h2e};
  logic [15:0] id_init_of [4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
  logic [15:0] exp_id [4];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Header as 160 bits, wire byte 0 in the top byte; checksum by folding the
  // plain integer sum of all ten words until it fits in 16 bits.
  function automatic logic [159:0] model_hdr(input logic [5:0] dscp, input int len,
                                             input logic [15:0] id,
                                             input logic [31:0] s, input logic [31:0] d);
    logic [15:0]  tot;
    logic [159:0] h;
    int           sum;
    tot = 16'(len + 20);
    h   = {8'h45, dscp, 2'b00, tot, id, 16'h4000, 8'd64, 8'd17, 16'h0000, s, d};
    sum = 0;
    for (int i = 0; i < 10; i++) sum += int'(h[159 - 16*i -: 16]);
    while (sum > 32'h0000_FFFF) sum = (sum & 32'h0000_FFFF) + (sum >> 16);
    h[79:64] = ~(sum[15:0]);
    return h;
  endfunction

  function automatic logic [127:0] exp_data(input logic [159:0] h, input int bp, input int b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < bp; k++) begin
      int idx;
      idx = b*bp + k;
      if (idx < 20) r[8*k +: 8] = h[159 - 8*idx -: 8];
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_keep(input int bp, input int b);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < bp; k++) if (b*bp + k < 20) r[k] = 1'b1;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the last-beat handshake.
  task automatic run_pkt(input int u, input logic [15:0] len, input logic [31:0] s,
                         input logic [31:0] d, input logic [159:0] h, input int stall);
    int b;
    int cyc;
    int nb;
    nb = nb_of[u];
    chk("req_ready_idle", rdy[u], 1'b1);
    req_v[u] = 1'b1;
    dlen[u]  = len;
    src_a[u] = s;
    dst_a[u] = d;
    @(posedge clk);
    #1;
    req_v[u] = 1'b0;
    dlen[u]  = 16'($urandom);
    src_a[u] = $urandom;
    dst_a[u] = $urandom;
    @(negedge clk);
    chk("lat_sum_v", hv[u], 1'b0);
    @(negedge clk);
    chk("lat_fold_v", hv[u], 1'b0);
    @(negedge clk);
    b   = 0;
    cyc = 0;
    while (b < nb && cyc < 500) begin
      hready[u] = ($urandom_range(99) >= stall);
      chk("beat_v", hv[u], 1'b1);
      chk("beat_data", hd[u], exp_data(h, bpb_of[u], b));
      chk("beat_keep", hk[u], exp_keep(bpb_of[u], b));
      chk("beat_last", hl[u], (b == nb - 1));
      chk("beat_rdy_low", rdy[u], 1'b0);
      if (hready[u]) b++;
      cyc++;
      @(negedge clk);
    end
    hready[u] = 1'b0;
    chk("beats_done", b, nb);
    chk("idle_after_v", hv[u], 1'b0);
    chk("ready_after_last", rdy[u], 1'b1);
  endtask

  task automatic send(input int u, input int len, input int stall);
    logic [31:0]  s;
    logic [31:0]  d;
    logic [159:0] h;
    s = $urandom;
    d = $urandom;
    h = model_hdr(dscp_of[u], len, exp_id[u], s, d);
    run_pkt(u, 16'(len), s, d, h, stall);
    exp_id[u] = exp_id[u] + 16'd1;
  endtask

  initial begin
    logic [159:0] h;
    logic [31:0]  s;
    logic [31:0]  d;
    int           len;

    reset  = 1'b1;
    req_v  = '0;
    hready = '0;
    for (int i = 0; i < 4; i++) begin
      dlen[i]  = '0;
      src_a[i] = '0;
      dst_a[i] = '0;
    end
    exp_id = id_init_of;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk("rst_ready", rdy[u], 1'b0);
      chk("rst_v", hv[u], 1'b0);
      chk("rst_last", hl[u], 1'b0);
      chk("rst_len_err", lerr[u], 1'b0);
      chk("rst_data", hd[u], 128'd0);
      chk("rst_keep", hk[u], 16'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Reference vector, then the same request back-to-back with ID 1.
    run_pkt(0, 16'd95, 32'hC0A8_0001, 32'hC0A8_00C7,
            160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7, 0);
    exp_id[0] = exp_id[0] + 16'd1;
    run_pkt(0, 16'd95, 32'hC0A8_0001, 32'hC0A8_00C7,
            160'h4500_0073_0001_4000_4011_B860_C0A8_0001_C0A8_00C7, 0);
    exp_id[0] = exp_id[0] + 16'd1;

    send(0, 65515, 30);

    // Overflowing total length: error pulse, no beats, ID untouched.
    chk("len_err_ready", rdy[0], 1'b1);
    req_v[0] = 1'b1;
    dlen[0]  = 16'd65516;
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    @(negedge clk);
    chk("len_err_pulse", lerr[0], 1'b1);
    chk("len_err_no_v", hv[0], 1'b0);
    chk("len_err_ready_kept", rdy[0], 1'b1);
    @(negedge clk);
    chk("len_err_one_cycle", lerr[0], 1'b0);
    repeat (4) begin
      chk("len_err_no_beats", hv[0], 1'b0);
      @(negedge clk);
    end
    send(0, $urandom_range(65515), 0);

    // ID wrap from FFFF, then random traffic with stalls at the other widths.
    for (int i = 0; i < 4; i++) send(1, $urandom_range(65515), 40);
    for (int i = 0; i < 3; i++) send(2, $urandom_range(65515), 40);
    for (int i = 0; i < 3; i++) send(3, $urandom_range(65515), 40);

    // Reset while beat 1 of a header is on the bus.
    s   = $urandom;
    d   = $urandom;
    len = $urandom_range(65515);
    h   = model_hdr(dscp_of[0], len, exp_id[0], s, d);
    req_v[0] = 1'b1;
    dlen[0]  = 16'(len);
    src_a[0] = s;
    dst_a[0] = d;
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    hready[0] = 1'b1;
    @(negedge clk);
    hready[0] = 1'b0;
    chk("pre_rst_beat1_v", hv[0], 1'b1);
    chk("pre_rst_beat1_data", hd[0], exp_data(h, 8, 1));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_v", hv[0], 1'b0);
    chk("mid_rst_ready", rdy[0], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", rdy[0], 1'b1);
    chk("post_rst_v", hv[0], 1'b0);
    exp_id = id_init_of;
    send(0, $urandom_range(65515), 20);
    send(1, $urandom_range(65515), 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
